// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the iterative multiply/divide unit
package mdu_pkg;

  typedef enum logic [1:0] {
    MUL  = 2'b00,
    MULU = 2'b01,
    DIV  = 2'b10,
    DIVU = 2'b11
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } mdu_state_t;

  localparam int MDU_ITERS = 32;

  // Divide-by-zero result: all-ones quotient, dividend passed through as remainder.
  localparam logic [31:0] MDU_DIV0_LO = 32'hFFFF_FFFF;
  // Result of any divide when the divider is compiled out.
  localparam logic [31:0] MDU_NODIV_RES = 32'h0000_0000;

endpackage

// File: rtl/mdu_iter_if.sv
// rtl/mdu_iter_if.sv - request/result bundle between the control FSM and mdu_iter
interface mdu_iter_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);

endinterface

// File: rtl/mdu_signfix.sv
// rtl/mdu_signfix.sv - conditional two's-complement negation of a result pair
// wide_i negates the pair as one 2*WIDTH number (product); otherwise each half on its own flag.
module mdu_signfix #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] pair_i,
  input  logic               wide_i,
  input  logic               neg_hi_i,
  input  logic               neg_lo_i,
  output logic [2*WIDTH-1:0] pair_o
);

  always_comb begin
    pair_o = pair_i;
    if (wide_i) begin
      if (neg_lo_i) pair_o = -pair_i;
    end else begin
      if (neg_hi_i) pair_o[2*WIDTH-1:WIDTH] = -pair_i[2*WIDTH-1:WIDTH];
      if (neg_lo_i) pair_o[WIDTH-1:0]       = -pair_i[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// rtl/mdu_iter.sv - iterative 32-bit multiply/divide unit, one result bit per cycle
// Define MDU_DIV_EN to build the restoring divider; without it DIV/DIVU return zero in one cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  mdu_iter_if.slave bus
);

  localparam int W = WIDTH;

  mdu_state_t       state_q, state_d;
  mdu_op_t          op_q, op_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d;
  logic             sgn_lo_q, sgn_lo_d;
  logic             sgn_hi_q, sgn_hi_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  mdu_op_t          op_in;
  logic             in_signed, in_div, accept, fix_wide;
  logic [W-1:0]     a_abs, b_abs;
  logic [W:0]       mul_sum;
  logic [2*W-1:0]   mul_next, fix_in, fix_out;

  assign op_in     = mdu_op_t'(bus.op);
  assign in_signed = (op_in == MUL) || (op_in == DIV);
  assign in_div    = (op_in == DIV) || (op_in == DIVU);
  assign a_abs     = (in_signed && bus.a[W-1]) ? -bus.a : bus.a;
  assign b_abs     = (in_signed && bus.b[W-1]) ? -bus.b : bus.b;
  assign accept    = bus.start && ((state_q == IDLE) || (state_q == DONE));
  assign fix_wide  = (op_q == MUL) || (op_q == MULU);

  // Shift-add: multiplier sits in acc low half and is consumed LSB first.
  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
  assign mul_next = acc_q[0] ? {mul_sum, acc_q[W-1:1]}
                             : {1'b0, acc_q[2*W-1:W], acc_q[W-1:1]};

`ifdef MDU_DIV_EN
  logic [W:0] rem_q, rem_d, div_trial;
  logic       div_ge, unused_rem_msb;

  // Restoring step: dividend bits shift out of acc low half, quotient bits shift in.
  assign div_trial      = {rem_q[W-1:0], acc_q[W-1]};
  assign div_ge         = div_trial >= {1'b0, opnd_q};
  assign fix_in         = fix_wide ? acc_q : {rem_q[W-1:0], acc_q[W-1:0]};
  assign unused_rem_msb = rem_q[W];
`else
  assign fix_in = acc_q;
`endif

  mdu_signfix #(.WIDTH(W)) u_signfix (
    .pair_i   (fix_in),
    .wide_i   (fix_wide),
    .neg_hi_i (sgn_hi_q),
    .neg_lo_i (sgn_lo_q),
    .pair_o   (fix_out)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    sgn_lo_d = sgn_lo_q;
    sgn_hi_d = sgn_hi_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
`ifdef MDU_DIV_EN
    rem_d    = rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d     = op_in;
          acc_d    = {{W{1'b0}}, a_abs};
          opnd_d   = b_abs;
          sgn_lo_d = in_signed && (bus.a[W-1] ^ bus.b[W-1]);
          sgn_hi_d = in_signed && bus.a[W-1];
          cnt_d    = '0;
          state_d  = RUN;
`ifdef MDU_DIV_EN
          rem_d    = '0;
          if (in_div && (bus.b == '0)) begin
            hi_d    = bus.a;
            lo_d    = MDU_DIV0_LO;
            state_d = DONE;
          end
`else
          if (in_div) begin
            hi_d    = MDU_NODIV_RES;
            lo_d    = MDU_NODIV_RES;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MDU_DIV_EN
        if (!fix_wide) begin
          rem_d = div_ge ? (div_trial - {1'b0, opnd_q}) : div_trial;
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};
        end else begin
          acc_d = mul_next;
        end
`else
        acc_d = mul_next;
`endif
        if (cnt_q == 6'(MDU_ITERS - 1)) state_d = FIX;
      end
      FIX: begin
        hi_d    = fix_out[2*W-1:W];
        lo_d    = fix_out[W-1:0];
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= MUL;
      acc_q    <= '0;
      opnd_q   <= '0;
      sgn_lo_q <= 1'b0;
      sgn_hi_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      rem_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      sgn_lo_q <= sgn_lo_d;
      sgn_hi_q <= sgn_hi_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef MDU_DIV_EN
      rem_q    <= rem_d;
`endif
    end
  end

  assign bus.busy = (state_q == RUN) || (state_q == FIX);
  assign bus.done = (state_q == DONE);
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
